// File: rtl/complex_row_vector_feeder_if.sv
// ---------------------------------------------------------------------------
// complex_row_vector_feeder_if
//
// Bundles every non-clock/non-reset signal of complex_row_vector_feeder:
//   command handshake : cmd_valid, cmd_ready, cmd_row
//   memory read port  : mem_rd_en, a_addr, p_addr, a_rdata, p_rdata
//   datapath side     : a, p, start_row_by_vector, number_of_multiples,
//                       decoder_read_now
//   status flags      : row_done, busy, cmd_error, spurious_ack, row_timeout
//
// Modports:
//   master : the feeder itself (drives addresses, chunks and status)
//   slave  : the surrounding system (command source, memories, datapath)
// ---------------------------------------------------------------------------
interface complex_row_vector_feeder_if #(
   parameter int ROW_W  = 8,
   parameter int ADDR_W = 10
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [ROW_W-1:0]  cmd_row;

   logic              mem_rd_en;
   logic [ADDR_W-1:0] a_addr;
   logic [ADDR_W-1:0] p_addr;
   logic [191:0]      a_rdata;
   logic [191:0]      p_rdata;

   logic [191:0]      a;
   logic [191:0]      p;
   logic              start_row_by_vector;
   logic [7:0]        number_of_multiples;
   logic              decoder_read_now;

   logic              row_done;
   logic              busy;
   logic              cmd_error;
   logic              spurious_ack;
   logic              row_timeout;

   modport master (
      input  cmd_valid, cmd_row, a_rdata, p_rdata, decoder_read_now,
      output cmd_ready, mem_rd_en, a_addr, p_addr, a, p,
             start_row_by_vector, number_of_multiples,
             row_done, busy, cmd_error, spurious_ack, row_timeout
   );

   modport slave (
      output cmd_valid, cmd_row, a_rdata, p_rdata, decoder_read_now,
      input  cmd_ready, mem_rd_en, a_addr, p_addr, a, p,
             start_row_by_vector, number_of_multiples,
             row_done, busy, cmd_error, spurious_ack, row_timeout
   );
endinterface

// File: rtl/complex_row_vector_feeder.sv
// ---------------------------------------------------------------------------
// complex_row_vector_feeder
//
// Upstream sequencer for complex_row_by_vector_with_control. A row command
// selects one matrix row; the row and the vector p are read from two
// synchronous memories one 192-bit word (three 64-bit complex entries) per
// cycle, the trailing lanes of the last chunk are zero-padded, and each chunk
// is presented on a/p together with a one-cycle start_row_by_vector strobe.
// The row then stays open until the datapath answers with decoder_read_now.
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : complex_row_vector_feeder_if.master (command, memory, datapath
//           and status signals)
//
// Optional feature: define ROW_FEEDER_TIMEOUT_EN to enable a drain watchdog
// that abandons the row after TIMEOUT_CYCLES cycles in DRAIN and pulses
// row_timeout. Without it, row_timeout is tied low and DRAIN waits forever.
// ---------------------------------------------------------------------------
module complex_row_vector_feeder #(
   parameter int ROW_LEN        = 3,
   parameter int N_ROWS         = 16,
   parameter int ROW_W          = 8,
   parameter int ADDR_W         = 10,
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic clk,
   input logic reset,
   complex_row_vector_feeder_if.master bus
);

   localparam int CHUNKS = (ROW_LEN + 2) / 3;
   localparam int K_W    = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN
   } state_t;

   state_t            state_q, state_d;
   logic [ROW_W-1:0]  row_q;
   logic [K_W-1:0]    k_q;

   logic              rd_pending_q;
   logic              rd_last_q;
   logic [K_W-1:0]    rd_k_q;
   logic              strobe_q;
   logic              strobe_last_q;
   logic              drained_q;
   logic              spurious_q;
   logic [191:0]      a_q, p_q;
   logic [191:0]      a_masked, p_masked;

   logic              cmd_ok;
   logic              issue_last;
   logic              ack_ok;
   logic              timeout_hit;

   logic              cmd_ready_c, busy_c, mem_rd_en_c;
   logic              row_done_c, cmd_error_c, row_timeout_c;

   assign cmd_ok     = bus.cmd_valid && (32'(bus.cmd_row) < 32'(N_ROWS));
   assign issue_last = (k_q == K_W'(CHUNKS - 1));

   // The ack is only honoured once the final strobe has left the bus;
   // drained_q goes high on the edge that ends the final strobe cycle.
   assign ack_ok     = (state_q == S_DRAIN) && drained_q && bus.decoder_read_now;

`ifdef ROW_FEEDER_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt_q;

   // Watchdog counter: zero on the first DRAIN cycle, one more every
   // following DRAIN cycle; held at zero everywhere else.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         to_cnt_q <= '0;
      end else if (state_q != S_DRAIN) begin
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_q + 1'b1;
      end
   end

   assign timeout_hit = (state_q == S_DRAIN) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES));
`else
   assign timeout_hit = 1'b0;
`endif

   // Control FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and handshake/status decode. A real acknowledge wins over
   // a watchdog expiry in the same cycle.
   always_comb begin
      state_d       = state_q;
      cmd_ready_c   = 1'b0;
      busy_c        = 1'b1;
      mem_rd_en_c   = 1'b0;
      row_done_c    = 1'b0;
      cmd_error_c   = 1'b0;
      row_timeout_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            cmd_ready_c = 1'b1;
            busy_c      = 1'b0;
            if (bus.cmd_valid) begin
               if (cmd_ok) begin
                  state_d = S_ISSUE;
               end else begin
                  cmd_error_c = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            mem_rd_en_c = 1'b1;
            if (issue_last) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (ack_ok) begin
               row_done_c = 1'b1;
               state_d    = S_IDLE;
            end else if (timeout_hit) begin
               row_timeout_c = 1'b1;
               state_d       = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Row latch and chunk index: k restarts at zero for every accepted row
   // and advances once per issued address pair.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row_q <= '0;
         k_q   <= '0;
      end else if (state_q == S_IDLE) begin
         k_q <= '0;
         if (cmd_ok) begin
            row_q <= bus.cmd_row;
         end
      end else if (state_q == S_ISSUE && !issue_last) begin
         k_q <= k_q + 1'b1;
      end
   end

   // Lanes whose entry index 3k+lane falls beyond the row are zeroed; only
   // the last chunk can contain such lanes.
   always_comb begin
      a_masked = bus.a_rdata;
      p_masked = bus.p_rdata;
      for (int lane = 0; lane < 3; lane++) begin
         if (3 * int'(rd_k_q) + lane >= ROW_LEN) begin
            a_masked[191 - 64*lane -: 64] = 64'b0;
            p_masked[191 - 64*lane -: 64] = 64'b0;
         end
      end
   end

   // Two-stage read pipeline: stage one marks that memory data arrives next
   // cycle, stage two registers the padded chunk and raises the strobe.
   // Reset clears both stages so in-flight reads never produce a strobe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_pending_q  <= 1'b0;
         rd_last_q     <= 1'b0;
         rd_k_q        <= '0;
         strobe_q      <= 1'b0;
         strobe_last_q <= 1'b0;
         a_q           <= '0;
         p_q           <= '0;
      end else begin
         rd_pending_q  <= mem_rd_en_c;
         rd_last_q     <= mem_rd_en_c && issue_last;
         if (mem_rd_en_c) begin
            rd_k_q <= k_q;
         end
         strobe_q      <= rd_pending_q;
         strobe_last_q <= rd_last_q;
         if (rd_pending_q) begin
            a_q <= a_masked;
            p_q <= p_masked;
         end
      end
   end

   // drained_q opens the acknowledge window after the final strobe;
   // spurious_q remembers any decoder_read_now seen outside that window.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         drained_q  <= 1'b0;
         spurious_q <= 1'b0;
      end else begin
         if (state_q == S_IDLE) begin
            drained_q <= 1'b0;
         end else if (strobe_q && strobe_last_q) begin
            drained_q <= 1'b1;
         end
         if (bus.decoder_read_now && !ack_ok) begin
            spurious_q <= 1'b1;
         end
      end
   end

   assign bus.cmd_ready           = cmd_ready_c;
   assign bus.busy                = busy_c;
   assign bus.mem_rd_en           = mem_rd_en_c;
   assign bus.row_done            = row_done_c;
   assign bus.cmd_error           = cmd_error_c;
   assign bus.row_timeout         = row_timeout_c;
   assign bus.spurious_ack        = spurious_q;
   assign bus.start_row_by_vector = strobe_q;
   assign bus.a                   = a_q;
   assign bus.p                   = p_q;
   assign bus.number_of_multiples = 8'(CHUNKS);

   // Address pair for chunk k; the matrix address wraps at ADDR_W bits.
   assign bus.a_addr = ADDR_W'(row_q) * ADDR_W'(CHUNKS) + ADDR_W'(k_q);
   assign bus.p_addr = ADDR_W'(k_q);

endmodule

// File: tb/tb_complex_row_vector_feeder.sv
// ---------------------------------------------------------------------------
// tb_complex_row_vector_feeder
//
// Directed bench with two feeder instances sharing clock and reset:
//   dut3 : ROW_LEN=3 (one chunk per row)
//   dut8 : ROW_LEN=8 (three chunks, last chunk has one padded lane)
// Each side has a synchronous memory model answering one cycle after
// mem_rd_en. Inputs are driven 2 time units after the rising edge and
// outputs are sampled 1 unit later.
// ---------------------------------------------------------------------------
module tb_complex_row_vector_feeder;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   complex_row_vector_feeder_if #(.ROW_W(8), .ADDR_W(10)) if3 ();
   complex_row_vector_feeder_if #(.ROW_W(8), .ADDR_W(10)) if8 ();

   complex_row_vector_feeder #(.ROW_LEN(3), .N_ROWS(16), .ROW_W(8), .ADDR_W(10), .TIMEOUT_CYCLES(64)) dut3 (
      .clk   (clk),
      .reset (reset),
      .bus   (if3.master)
   );

   complex_row_vector_feeder #(.ROW_LEN(8), .N_ROWS(16), .ROW_W(8), .ADDR_W(10), .TIMEOUT_CYCLES(64)) dut8 (
      .clk   (clk),
      .reset (reset),
      .bus   (if8.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents: every lane is nonzero and tagged with its address.
   function automatic logic [191:0] a_word(input logic [9:0] addr);
      return {48'hA0A0_1111_0000, 6'd0, addr, 48'hA1A1_2222_0000, 6'd0, addr, 48'hA2A2_3333_0000, 6'd0, addr};
   endfunction

   function automatic logic [191:0] p_word(input logic [9:0] addr);
      return {48'h5050_4444_0000, 6'd0, addr, 48'h5151_5555_0000, 6'd0, addr, 48'h5252_6666_0000, 6'd0, addr};
   endfunction

   always @(posedge clk) begin
      if (if3.mem_rd_en) begin
         if3.a_rdata <= a_word(if3.a_addr);
         if3.p_rdata <= p_word(if3.p_addr);
      end
      if (if8.mem_rd_en) begin
         if8.a_rdata <= a_word(if8.a_addr);
         if8.p_rdata <= p_word(if8.p_addr);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      if3.cmd_valid = 1'b0; if3.cmd_row = '0; if3.decoder_read_now = 1'b0;
      if8.cmd_valid = 1'b0; if8.cmd_row = '0; if8.decoder_read_now = 1'b0;
      step(); step();
      #1;
      if (if3.cmd_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_cmd_ready got=%b want=1", if3.cmd_ready); end
      n_cmp++;
      if (if3.busy !== 1'b0 || if3.mem_rd_en !== 1'b0 || if3.start_row_by_vector !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ctrl busy=%b rd=%b strobe=%b want 0/0/0", if3.busy, if3.mem_rd_en, if3.start_row_by_vector); end
      n_cmp++;
      if (if3.number_of_multiples !== 8'd1) begin n_err++; $display("[TB] FAIL reset_nom3 got=%0d want=1", if3.number_of_multiples); end
      n_cmp++;
      if (if8.number_of_multiples !== 8'd3) begin n_err++; $display("[TB] FAIL reset_nom8 got=%0d want=3", if8.number_of_multiples); end
      n_cmp++;
      if (if8.a !== 192'b0 || if8.p !== 192'b0 || if8.spurious_ack !== 1'b0 || if8.row_done !== 1'b0) begin n_err++; $display("[TB] FAIL reset_data a=%h spur=%b done=%b want zeros", if8.a, if8.spurious_ack, if8.row_done); end
      n_cmp++;
      reset = 1'b1;
      step();
   endtask

   task automatic test_single_row();
      logic [191:0] exp_a, exp_p;
      int bad;
      exp_a = a_word(10'd2);
      exp_p = p_word(10'd0);
      if3.cmd_valid = 1'b1; if3.cmd_row = 8'd2;
      #1;
      if (if3.cmd_ready !== 1'b1) begin n_err++; $display("[TB] FAIL single_ready got=%b want=1", if3.cmd_ready); end
      n_cmp++;
      step();
      if3.cmd_valid = 1'b0;
      #1;
      if (if3.mem_rd_en !== 1'b1 || if3.a_addr !== 10'd2 || if3.p_addr !== 10'd0 || if3.busy !== 1'b1) begin n_err++; $display("[TB] FAIL single_issue rd=%b a_addr=%0d p_addr=%0d busy=%b want 1/2/0/1", if3.mem_rd_en, if3.a_addr, if3.p_addr, if3.busy); end
      n_cmp++;
      step();
      #1;
      if (if3.mem_rd_en !== 1'b0 || if3.start_row_by_vector !== 1'b0) begin n_err++; $display("[TB] FAIL single_gap rd=%b strobe=%b want 0/0", if3.mem_rd_en, if3.start_row_by_vector); end
      n_cmp++;
      step();
      #1;
      if (if3.start_row_by_vector !== 1'b1 || if3.a !== exp_a || if3.p !== exp_p) begin n_err++; $display("[TB] FAIL single_strobe strobe=%b a=%h p=%h want 1 a=%h p=%h", if3.start_row_by_vector, if3.a, if3.p, exp_a, exp_p); end
      n_cmp++;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         #1;
         if (if3.start_row_by_vector !== 1'b0 || if3.row_done !== 1'b0 || if3.busy !== 1'b1 || if3.a !== exp_a) bad++;
      end
      if (bad != 0) begin n_err++; $display("[TB] FAIL single_hold bad_cycles=%0d want=0", bad); end
      n_cmp++;
      step();
      if3.decoder_read_now = 1'b1;
      #1;
      if (if3.row_done !== 1'b1) begin n_err++; $display("[TB] FAIL single_done got=%b want=1", if3.row_done); end
      n_cmp++;
      step();
      if3.decoder_read_now = 1'b0;
      #1;
      if (if3.row_done !== 1'b0 || if3.cmd_ready !== 1'b1 || if3.busy !== 1'b0 || if3.spurious_ack !== 1'b0) begin n_err++; $display("[TB] FAIL single_idle done=%b ready=%b busy=%b spur=%b want 0/1/0/0", if3.row_done, if3.cmd_ready, if3.busy, if3.spurious_ack); end
      n_cmp++;
   endtask

   task automatic test_padding();
      logic [191:0] w, exp_a, exp_p;
      if8.cmd_valid = 1'b1; if8.cmd_row = 8'd1;
      step();
      if8.cmd_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         if (if8.mem_rd_en !== 1'b1 || if8.a_addr !== 10'(3 + k) || if8.p_addr !== 10'(k)) begin n_err++; $display("[TB] FAIL pad_addr k=%0d a_addr=%0d p_addr=%0d want %0d/%0d", k, if8.a_addr, if8.p_addr, 3 + k, k); end
         n_cmp++;
         if (k == 2) begin
            exp_a = a_word(10'd3);
            exp_p = p_word(10'd0);
            if (if8.start_row_by_vector !== 1'b1 || if8.a !== exp_a || if8.p !== exp_p) begin n_err++; $display("[TB] FAIL pad_chunk0 strobe=%b a=%h want a=%h", if8.start_row_by_vector, if8.a, exp_a); end
            n_cmp++;
         end
         step();
      end
      #1;
      exp_a = a_word(10'd4);
      exp_p = p_word(10'd1);
      if (if8.mem_rd_en !== 1'b0 || if8.start_row_by_vector !== 1'b1 || if8.a !== exp_a || if8.p !== exp_p) begin n_err++; $display("[TB] FAIL pad_chunk1 rd=%b strobe=%b a=%h want a=%h", if8.mem_rd_en, if8.start_row_by_vector, if8.a, exp_a); end
      n_cmp++;
      step();
      #1;
      w = a_word(10'd5);
      exp_a = {w[191:64], 64'b0};
      w = p_word(10'd2);
      exp_p = {w[191:64], 64'b0};
      if (if8.start_row_by_vector !== 1'b1 || if8.a !== exp_a || if8.p !== exp_p) begin n_err++; $display("[TB] FAIL pad_chunk2 strobe=%b a=%h p=%h want a=%h p=%h", if8.start_row_by_vector, if8.a, if8.p, exp_a, exp_p); end
      n_cmp++;
      step();
      if8.decoder_read_now = 1'b1;
      #1;
      if (if8.row_done !== 1'b1 || if8.start_row_by_vector !== 1'b0 || if8.a !== exp_a) begin n_err++; $display("[TB] FAIL pad_done done=%b strobe=%b want 1/0 with a held", if8.row_done, if8.start_row_by_vector); end
      n_cmp++;
   endtask

   task automatic test_back_to_back();
      step();
      if8.decoder_read_now = 1'b0;
      if8.cmd_valid = 1'b1; if8.cmd_row = 8'd0;
      #1;
      if (if8.cmd_ready !== 1'b1 || if8.row_done !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_ready ready=%b done=%b want 1/0", if8.cmd_ready, if8.row_done); end
      n_cmp++;
      step();
      if8.cmd_valid = 1'b0;
      #1;
      if (if8.mem_rd_en !== 1'b1 || if8.a_addr !== 10'd0) begin n_err++; $display("[TB] FAIL b2b_issue rd=%b a_addr=%0d want 1/0", if8.mem_rd_en, if8.a_addr); end
      n_cmp++;
      for (int i = 0; i < 5; i++) step();
      if8.decoder_read_now = 1'b1;
      #1;
      if (if8.row_done !== 1'b1 || if8.spurious_ack !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_done done=%b spur=%b want 1/0", if8.row_done, if8.spurious_ack); end
      n_cmp++;
      step();
      if8.decoder_read_now = 1'b0;
   endtask

   task automatic test_bad_cmd();
      if3.cmd_valid = 1'b1; if3.cmd_row = 8'd16;
      #1;
      if (if3.cmd_error !== 1'b1 || if3.mem_rd_en !== 1'b0 || if3.busy !== 1'b0) begin n_err++; $display("[TB] FAIL bad_err err=%b rd=%b busy=%b want 1/0/0", if3.cmd_error, if3.mem_rd_en, if3.busy); end
      n_cmp++;
      step();
      if3.cmd_valid = 1'b0;
      #1;
      if (if3.cmd_error !== 1'b0 || if3.mem_rd_en !== 1'b0 || if3.busy !== 1'b0 || if3.cmd_ready !== 1'b1) begin n_err++; $display("[TB] FAIL bad_after err=%b rd=%b busy=%b ready=%b want 0/0/0/1", if3.cmd_error, if3.mem_rd_en, if3.busy, if3.cmd_ready); end
      n_cmp++;
   endtask

   task automatic test_spurious();
      logic [191:0] exp_a;
      exp_a = a_word(10'd5);
      if3.decoder_read_now = 1'b1;
      step();
      if3.decoder_read_now = 1'b0;
      #1;
      if (if3.spurious_ack !== 1'b1 || if3.busy !== 1'b0) begin n_err++; $display("[TB] FAIL spur_idle spur=%b busy=%b want 1/0", if3.spurious_ack, if3.busy); end
      n_cmp++;
      if3.cmd_valid = 1'b1; if3.cmd_row = 8'd5;
      step();
      if3.cmd_valid = 1'b0;
      #1;
      if (if3.a_addr !== 10'd5 || if3.mem_rd_en !== 1'b1) begin n_err++; $display("[TB] FAIL spur_issue a_addr=%0d rd=%b want 5/1", if3.a_addr, if3.mem_rd_en); end
      n_cmp++;
      step();
      step();
      if3.decoder_read_now = 1'b1;
      #1;
      if (if3.start_row_by_vector !== 1'b1 || if3.row_done !== 1'b0 || if3.a !== exp_a) begin n_err++; $display("[TB] FAIL spur_early strobe=%b done=%b a=%h want 1/0 a=%h", if3.start_row_by_vector, if3.row_done, if3.a, exp_a); end
      n_cmp++;
      step();
      if3.decoder_read_now = 1'b0;
      #1;
      if (if3.busy !== 1'b1) begin n_err++; $display("[TB] FAIL spur_still_busy got=%b want=1", if3.busy); end
      n_cmp++;
      step();
      if3.decoder_read_now = 1'b1;
      #1;
      if (if3.row_done !== 1'b1) begin n_err++; $display("[TB] FAIL spur_done got=%b want=1", if3.row_done); end
      n_cmp++;
      step();
      if3.decoder_read_now = 1'b0;
      #1;
      if (if3.cmd_ready !== 1'b1 || if3.spurious_ack !== 1'b1) begin n_err++; $display("[TB] FAIL spur_sticky ready=%b spur=%b want 1/1", if3.cmd_ready, if3.spurious_ack); end
      n_cmp++;
   endtask

   task automatic test_reset_mid_row();
      logic [191:0] w, exp_a;
      int bad;
      if8.cmd_valid = 1'b1; if8.cmd_row = 8'd1;
      step();
      if8.cmd_valid = 1'b0;
      step();
      reset = 1'b0;
      #1;
      if (if8.busy !== 1'b0 || if8.mem_rd_en !== 1'b0 || if8.cmd_ready !== 1'b1 || if8.start_row_by_vector !== 1'b0 || if8.a !== 192'b0 || if8.p !== 192'b0) begin n_err++; $display("[TB] FAIL rst_mid busy=%b rd=%b ready=%b strobe=%b a=%h want idle/zero", if8.busy, if8.mem_rd_en, if8.cmd_ready, if8.start_row_by_vector, if8.a); end
      n_cmp++;
      if (if3.spurious_ack !== 1'b0) begin n_err++; $display("[TB] FAIL rst_spur_clear got=%b want=0", if3.spurious_ack); end
      n_cmp++;
      bad = 0;
      step(); #1; if (if8.start_row_by_vector !== 1'b0) bad++;
      step();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (if8.start_row_by_vector !== 1'b0 || if8.busy !== 1'b0 || if8.a !== 192'b0) bad++;
         step();
      end
      if (bad != 0) begin n_err++; $display("[TB] FAIL rst_no_strobe bad_cycles=%0d want=0", bad); end
      n_cmp++;
      if8.cmd_valid = 1'b1; if8.cmd_row = 8'd2;
      step();
      if8.cmd_valid = 1'b0;
      #1;
      if (if8.a_addr !== 10'd6 || if8.p_addr !== 10'd0 || if8.mem_rd_en !== 1'b1) begin n_err++; $display("[TB] FAIL rst_restart a_addr=%0d p_addr=%0d want 6/0", if8.a_addr, if8.p_addr); end
      n_cmp++;
      step(); step(); step(); step();
      #1;
      w = a_word(10'd8);
      exp_a = {w[191:64], 64'b0};
      if (if8.start_row_by_vector !== 1'b1 || if8.a !== exp_a) begin n_err++; $display("[TB] FAIL rst_last_chunk strobe=%b a=%h want 1 a=%h", if8.start_row_by_vector, if8.a, exp_a); end
      n_cmp++;
      step();
      if8.decoder_read_now = 1'b1;
      #1;
      if (if8.row_done !== 1'b1) begin n_err++; $display("[TB] FAIL rst_done got=%b want=1", if8.row_done); end
      n_cmp++;
      step();
      if8.decoder_read_now = 1'b0;
   endtask

   task automatic test_timeout();
      int bad;
      if3.cmd_valid = 1'b1; if3.cmd_row = 8'd0;
      step();
      if3.cmd_valid = 1'b0;
      step();
      bad = 0;
`ifdef ROW_FEEDER_TIMEOUT_EN
      for (int i = 0; i < 64; i++) begin
         #1;
         if (if3.row_timeout !== 1'b0 || if3.busy !== 1'b1) bad++;
         step();
      end
      if (bad != 0) begin n_err++; $display("[TB] FAIL to_early bad_cycles=%0d want=0", bad); end
      n_cmp++;
      #1;
      if (if3.row_timeout !== 1'b1 || if3.row_done !== 1'b0) begin n_err++; $display("[TB] FAIL to_pulse timeout=%b done=%b want 1/0", if3.row_timeout, if3.row_done); end
      n_cmp++;
      step();
      #1;
      if (if3.row_timeout !== 1'b0 || if3.busy !== 1'b0 || if3.cmd_ready !== 1'b1) begin n_err++; $display("[TB] FAIL to_idle timeout=%b busy=%b ready=%b want 0/0/1", if3.row_timeout, if3.busy, if3.cmd_ready); end
      n_cmp++;
      if3.decoder_read_now = 1'b1;
      step();
      if3.decoder_read_now = 1'b0;
      #1;
      if (if3.spurious_ack !== 1'b1 || if3.row_done !== 1'b0) begin n_err++; $display("[TB] FAIL to_late_ack spur=%b done=%b want 1/0", if3.spurious_ack, if3.row_done); end
      n_cmp++;
`else
      for (int i = 0; i < 210; i++) begin
         #1;
         if (if3.row_timeout !== 1'b0 || if3.busy !== 1'b1) bad++;
         step();
      end
      if (bad != 0) begin n_err++; $display("[TB] FAIL no_to_busy bad_cycles=%0d want=0", bad); end
      n_cmp++;
      if3.decoder_read_now = 1'b1;
      #1;
      if (if3.row_done !== 1'b1) begin n_err++; $display("[TB] FAIL no_to_done got=%b want=1", if3.row_done); end
      n_cmp++;
      step();
      if3.decoder_read_now = 1'b0;
      #1;
      if (if3.busy !== 1'b0 || if3.spurious_ack !== 1'b0) begin n_err++; $display("[TB] FAIL no_to_idle busy=%b spur=%b want 0/0", if3.busy, if3.spurious_ack); end
      n_cmp++;
`endif
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_single_row();
      test_padding();
      test_back_to_back();
      test_bad_cmd();
      test_spurious();
      test_reset_mid_row();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
